toggle_rr_scheduler: RTL

TOGGLE_RR_SCHEDULER -- requirements
Module: toggle_rr_scheduler

---
 rtl/toggle_rr_scheduler_pkg.sv | 19 +
 rtl/toggle_rr_scheduler_core.sv | 29 ++
 rtl/toggle_rr_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/toggle_rr_scheduler_pkg.sv
// Shared definitions for the round-robin toggle scheduler: FSM state encoding
// and the width helper used to size index and counter fields.
package toggle_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int N_REQ_DEFAULT     = 4;
    localparam int MAX_BURST_DEFAULT = 8;

    // Bits needed to encode values 0..n-1, never less than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/toggle_rr_scheduler_core.sv
// Shared toggle state: cleared at the start of a session, flipped by each
// consumed data bit that is high.
module toggle_core (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic r_toggle;

    // Toggle register with reset, session clear and conditional flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_toggle <= 1'b0;
        end else if (clr) begin
            r_toggle <= 1'b0;
        end else if (en) begin
            r_toggle <= r_toggle ^ din;
        end else begin
            r_toggle <= r_toggle;
        end
    end

    assign dout = r_toggle;

endmodule

// File: rtl/toggle_rr_scheduler.sv
// Round-robin scheduler granting one requester at a time to a shared toggle
// core; each session ends on request drop or after MAX_BURST consumed bits.
module toggle_rr_scheduler
    import toggle_rr_scheduler_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEFAULT,
    parameter  int MAX_BURST = MAX_BURST_DEFAULT,
    localparam int ID_W      = width_of(N_REQ),
    localparam int CNT_W     = width_of(MAX_BURST + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
    output logic [N_REQ-1:0] gnt,
    output logic             dout,
    output logic             result_valid,
    output logic             result,
    output logic [ID_W-1:0]  result_id
);

    state_e             r_state;
    logic [ID_W-1:0]    r_owner;
    logic [ID_W-1:0]    r_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_result_valid;
    logic               r_result;
    logic [ID_W-1:0]    r_result_id;

    logic [ID_W-1:0]    w_pick;
    logic [ID_W-1:0]    w_idx;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_any_req;
    logic               w_owner_req;
    logic               w_owner_din;
    logic               w_clr;
    logic               w_en;
    logic               w_core_dout;
    logic               w_toggle_next;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_last;
    logic [ID_W-1:0]    w_ptr_next;

    // Rotating priority search: walking from the farthest slot back to r_ptr
    // leaves the first requester at or above r_ptr as the winner.
    always_comb begin
        w_pick = r_ptr;
        w_idx  = r_ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx  = ID_W'((int'(r_ptr) + i) % N_REQ);
            w_pick = req[w_idx] ? w_idx : w_pick;
        end
        w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
    end

    // Session datapath controls derived from the current owner.
    always_comb begin
        w_any_req     = |req;
        w_owner_req   = req[r_owner];
        w_owner_din   = din[r_owner];
        w_en          = (r_state == ST_GRANT) && w_owner_req;
        w_clr         = (r_state == ST_IDLE) && w_any_req;
        w_toggle_next = w_core_dout ^ (w_en & w_owner_din);
        w_count_inc   = r_count + CNT_W'(1);
        w_last        = w_owner_req && (w_count_inc == CNT_W'(MAX_BURST));
        w_ptr_next    = (r_owner == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : r_owner + ID_W'(1);
    end

    toggle_core u_core (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .din  (w_owner_din),
        .dout (w_core_dout)
    );

    // Scheduler FSM with registered grant and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_owner        <= {ID_W{1'b0}};
            r_ptr          <= {ID_W{1'b0}};
            r_count        <= {CNT_W{1'b0}};
            r_gnt          <= {N_REQ{1'b0}};
            r_result_valid <= 1'b0;
            r_result       <= 1'b0;
            r_result_id    <= {ID_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_result_valid <= 1'b0;
                    if (w_any_req) begin
                        r_state <= ST_GRANT;
                        r_owner <= w_pick;
                        r_gnt   <= w_onehot;
                        r_count <= {CNT_W{1'b0}};
                    end else begin
                        r_gnt   <= {N_REQ{1'b0}};
                    end
                end
                ST_GRANT: begin
                    if (w_owner_req) begin
                        r_count <= w_count_inc;
                    end else begin
                        r_count <= r_count;
                    end
                    // A dropped request ends the session without consuming din.
                    if (!w_owner_req || w_last) begin
                        r_state        <= ST_DONE;
                        r_gnt          <= {N_REQ{1'b0}};
                        r_result_valid <= 1'b1;
                        r_result       <= w_toggle_next;
                        r_result_id    <= r_owner;
                    end else begin
                        r_state        <= ST_GRANT;
                    end
                end
                ST_DONE: begin
                    r_result_valid <= 1'b0;
                    r_ptr          <= w_ptr_next;
                    r_state        <= ST_IDLE;
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_gnt          <= {N_REQ{1'b0}};
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign dout         = w_core_dout;
    assign result_valid = r_result_valid;
    assign result       = r_result;
    assign result_id    = r_result_id;

endmodule
